// File: rtl/lcd_pkg.sv
// Shared opcode constants, opcode type and sequencer state encoding for the
// LCD command sequencer.
package lcd_pkg;

  typedef logic [3:0] lcd_op_t;

  localparam lcd_op_t CMD_WRITE       = 4'd0;
  localparam lcd_op_t CMD_SHIFT_UP    = 4'd1;
  localparam lcd_op_t CMD_SHIFT_DOWN  = 4'd2;
  localparam lcd_op_t CMD_SHIFT_LEFT  = 4'd3;
  localparam lcd_op_t CMD_SHIFT_RIGHT = 4'd4;
  localparam lcd_op_t CMD_MAX         = 4'd5;
  localparam lcd_op_t CMD_MIN         = 4'd6;
  localparam lcd_op_t CMD_AVERAGE     = 4'd7;
  localparam lcd_op_t CMD_ROT_CCW     = 4'd8;
  localparam lcd_op_t CMD_ROT_CW      = 4'd9;
  localparam lcd_op_t CMD_MIRROR_X    = 4'd10;
  localparam lcd_op_t CMD_MIRROR_Y    = 4'd11;

  localparam int MAX_OP_DEF = 11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Host-side and controller-side signals of the command sequencer.
// master = host/controller side, slave = sequencer.
interface lcd_cmd_sequencer_if
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8
);
  lcd_op_t                  host_cmd;
  logic                     host_push;
  logic                     host_full;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     lcd_busy;
  logic                     lcd_done;
  lcd_op_t                  lcd_cmd;
  logic                     lcd_cmd_valid;
  logic                     seq_busy;
  logic                     seq_done;
  logic                     err_illegal;
  logic                     err_timeout;
  logic [7:0]               issued_cnt;

  modport master (
    output host_cmd, host_push, lcd_busy, lcd_done,
    input  host_full, fifo_count, lcd_cmd, lcd_cmd_valid, seq_busy,
           seq_done, err_illegal, err_timeout, issued_cnt
  );

  modport slave (
    input  host_cmd, host_push, lcd_busy, lcd_done,
    output host_full, fifo_count, lcd_cmd, lcd_cmd_valid, seq_busy,
           seq_done, err_illegal, err_timeout, issued_cnt
  );
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers and a show-ahead head word.
// A push at full is taken only when a pop frees a slot in the same cycle.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  lcd_op_t                  din,
  output lcd_op_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  lcd_op_t        mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues host opcodes and issues them one at a time to the LCD controller,
// gated on the end of its image load and tracked through busy/done.
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4,
  parameter int MAX_OP      = MAX_OP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  lcd_cmd_sequencer_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  seq_state_e        state_q;
  lcd_op_t           lcd_cmd_q;
  logic              lcd_cmd_valid_q;
  logic              seq_done_q, err_illegal_q, err_timeout_q;
  logic [7:0]        issued_cnt_q;
  logic [TW-1:0]     to_cnt_q;
  logic              init_armed_q;

  lcd_op_t           head;
  logic              fifo_empty, fifo_full;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic              illegal, init_exit, issue;

  assign illegal = bus.host_push && (bus.host_cmd > 4'(MAX_OP));

  // After one sampled cycle in INIT, a low busy means either a 1->0 fall or a
  // second consecutive low with no load seen; both end the wait.
  assign init_exit = (state_q == ST_INIT) && init_armed_q && !bus.lcd_busy;
  assign issue     = ((state_q == ST_IDLE) || init_exit) && !fifo_empty && !bus.lcd_busy;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.host_push && !illegal),
    .pop   (issue),
    .din   (bus.host_cmd),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_INIT;
      lcd_cmd_q       <= '0;
      lcd_cmd_valid_q <= 1'b0;
      seq_done_q      <= 1'b0;
      err_illegal_q   <= 1'b0;
      err_timeout_q   <= 1'b0;
      issued_cnt_q    <= '0;
      to_cnt_q        <= '0;
      init_armed_q    <= 1'b0;
    end else begin
      lcd_cmd_valid_q <= 1'b0;
      if (illegal) err_illegal_q <= 1'b1;
      if (issue) begin
        lcd_cmd_q       <= head;
        lcd_cmd_valid_q <= 1'b1;
        to_cnt_q        <= '0;
        state_q         <= ST_WAIT_ACK;
        if (issued_cnt_q != 8'hFF) issued_cnt_q <= issued_cnt_q + 8'd1;
      end else begin
        unique case (state_q)
          ST_INIT: begin
            init_armed_q <= 1'b1;
            if (init_exit) state_q <= ST_IDLE;
          end
          ST_WAIT_ACK: begin
            if (bus.lcd_busy) state_q <= ST_WAIT_DONE;
            else if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
              err_timeout_q <= 1'b1;
              state_q       <= ST_IDLE;
            end else to_cnt_q <= to_cnt_q + 1'b1;
          end
          ST_WAIT_DONE: begin
            // The write-out is the only command that finishes on done.
            if (lcd_cmd_q == CMD_WRITE) begin
              if (bus.lcd_done) begin
                seq_done_q <= 1'b1;
                state_q    <= ST_FINISH;
              end
            end else if (!bus.lcd_busy) state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.lcd_cmd       = lcd_cmd_q;
  assign bus.lcd_cmd_valid = lcd_cmd_valid_q;
  assign bus.seq_done      = seq_done_q;
  assign bus.err_illegal   = err_illegal_q;
  assign bus.err_timeout   = err_timeout_q;
  assign bus.issued_cnt    = issued_cnt_q;
  assign bus.host_full     = fifo_full;
  assign bus.fifo_count    = fifo_cnt;
  // Gated by reset so the flag reads 0 while held in reset despite INIT.
  assign bus.seq_busy      = reset && (((state_q != ST_IDLE) && (state_q != ST_FINISH))
                                       || (fifo_cnt != '0));

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with an inline LCD controller model.
module tb_lcd_cmd_sequencer;
  import lcd_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(4), .MAX_OP(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Controller model: on a valid it raises busy for m_lat cycles (if m_ack);
  // a write additionally pulses done as busy falls.
  int      m_lat = 1;
  bit      m_ack = 1'b1;
  int      busy_cnt = 0;
  bit      done_pend = 1'b0;
  lcd_op_t log_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (bus.lcd_cmd_valid) begin
      check("valid_while_busy", 32'(bus.lcd_busy), 0);
      log_q.push_back(bus.lcd_cmd);
    end
    if (bus.lcd_done) bus.lcd_done = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        bus.lcd_busy = 1'b0;
        if (done_pend) begin
          bus.lcd_done = 1'b1;
          done_pend    = 1'b0;
        end
      end
    end
    if (bus.lcd_cmd_valid && m_ack) begin
      bus.lcd_busy = 1'b1;
      busy_cnt     = m_lat;
      done_pend    = (bus.lcd_cmd == CMD_WRITE);
    end
  endtask

  task automatic push(input int op);
    bus.host_cmd  = 4'(op);
    bus.host_push = 1'b1;
    tick();
    bus.host_push = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   32'(bus.lcd_cmd_valid), 0);
    check({tag, "_cmd"},     32'(bus.lcd_cmd), 0);
    check({tag, "_seqbusy"}, 32'(bus.seq_busy), 0);
    check({tag, "_seqdone"}, 32'(bus.seq_done), 0);
    check({tag, "_eill"},    32'(bus.err_illegal), 0);
    check({tag, "_eto"},     32'(bus.err_timeout), 0);
    check({tag, "_issued"},  32'(bus.issued_cnt), 0);
    check({tag, "_full"},    32'(bus.host_full), 0);
    check({tag, "_count"},   32'(bus.fifo_count), 0);
  endtask

  initial begin
    lcd_op_t exp2 [4] = '{4'd1, 4'd3, 4'd4, 4'd9};
    lcd_op_t exp5 [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11};
    int n;

    reset         = 1'b0;
    bus.host_cmd  = '0;
    bus.host_push = 1'b0;
    bus.lcd_busy  = 1'b1;
    bus.lcd_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b1;

    // 1: image load holds busy for 64 cycles; queued 2 waits for the fall
    push(2);
    repeat (62) tick();
    check("t1_no_early_issue", 32'(log_q.size()), 0);
    check("t1_count", 32'(bus.fifo_count), 1);
    check("t1_seq_busy", 32'(bus.seq_busy), 1);
    bus.lcd_busy = 1'b0;
    tick();
    check("t1_issued_now", 32'(log_q.size()), 1);
    check("t1_cmd", 32'(log_q[0]), 2);
    check("t1_issued_cnt", 32'(bus.issued_cnt), 1);
    tick();
    check("t1_valid_one_cycle", 32'(bus.lcd_cmd_valid), 0);

    // 2: back-to-back pushes issue in order
    push(1); push(3); push(4); push(9);
    repeat (30) tick();
    check("t2_log_size", 32'(log_q.size()), 5);
    for (int i = 0; i < 4; i++) check("t2_order", 32'(log_q[i+1]), 32'(exp2[i]));
    check("t2_count", 32'(bus.fifo_count), 0);
    check("t2_seq_busy", 32'(bus.seq_busy), 0);
    check("t2_issued_cnt", 32'(bus.issued_cnt), 5);

    // 3: illegal opcodes are screened out
    check("t3_eill_before", 32'(bus.err_illegal), 0);
    push(12); push(15);
    repeat (3) tick();
    check("t3_eill", 32'(bus.err_illegal), 1);
    check("t3_count", 32'(bus.fifo_count), 0);
    check("t3_no_issue", 32'(bus.issued_cnt), 5);
    push(5);
    repeat (6) tick();
    check("t3_log_size", 32'(log_q.size()), 6);
    check("t3_cmd5", 32'(log_q[5]), 5);
    check("t3_issued_cnt", 32'(bus.issued_cnt), 6);

    // 5: overfill while busy, then push+pop at full
    bus.lcd_busy = 1'b1;
    for (int i = 1; i <= DEPTH + 2; i++) push(i);
    check("t5_full", 32'(bus.host_full), 1);
    check("t5_count", 32'(bus.fifo_count), DEPTH);
    bus.lcd_busy = 1'b0;
    push(11);
    check("t5_pushpop_count", 32'(bus.fifo_count), DEPTH);
    repeat (40) tick();
    check("t5_log_size", 32'(log_q.size()), 15);
    for (int i = 0; i < 9; i++) check("t5_order", 32'(log_q[i+6]), 32'(exp5[i]));
    check("t5_drained", 32'(bus.fifo_count), 0);
    check("t5_issued_cnt", 32'(bus.issued_cnt), 15);

    // 6a: busy never rises -> timeout after 4 wait cycles, next command goes
    m_ack = 1'b0;
    push(7); push(6);
    repeat (3) tick();
    check("t6_eto_early", 32'(bus.err_timeout), 0);
    tick();
    check("t6_eto", 32'(bus.err_timeout), 1);
    m_ack = 1'b1;
    tick();
    check("t6_next_valid", 32'(bus.lcd_cmd_valid), 1);
    check("t6_next_cmd", 32'(bus.lcd_cmd), 6);
    check("t6_issued_cnt", 32'(bus.issued_cnt), 17);
    repeat (4) tick();

    // 6b: asynchronous reset in WAIT_DONE
    m_lat = 20;
    push(3); push(4); push(5);
    repeat (3) tick();
    check("t6_pre_count", 32'(bus.fifo_count), 2);
    check("t6_pre_seq_busy", 32'(bus.seq_busy), 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    busy_cnt     = 0;
    done_pend    = 1'b0;
    bus.lcd_busy = 1'b0;
    bus.lcd_done = 1'b0;
    m_lat        = 64;
    log_q.delete();
    @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // INIT exit on two low cycles with no load seen, then 4: write-out
    push(0);
    check("t4_init_hold", 32'(log_q.size()), 0);
    check("t4_count", 32'(bus.fifo_count), 1);
    tick();
    check("t4_issued", 32'(log_q.size()), 1);
    check("t4_cmd", 32'(log_q[0]), 0);
    check("t4_issued_cnt", 32'(bus.issued_cnt), 1);
    n = 0;
    while (!bus.lcd_done && n < 100) begin
      tick();
      n++;
    end
    check("t4_done_seen", 32'(bus.lcd_done), 1);
    check("t4_seq_done_early", 32'(bus.seq_done), 0);
    tick();
    check("t4_seq_done", 32'(bus.seq_done), 1);
    push(1);
    check("t4_finish_count", 32'(bus.fifo_count), 1);
    repeat (10) tick();
    check("t4_no_issue", 32'(log_q.size()), 1);
    check("t4_issued_final", 32'(bus.issued_cnt), 1);
    check("t4_seq_busy", 32'(bus.seq_busy), 1);
    check("t4_seq_done_sticky", 32'(bus.seq_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
